// File: rtl/asic_result_packetizer.sv
// Return-path packetizer: buffers ASIC result frames, counts bit errors per frame and
// emits each complete frame as one Avalon-ST packet; overflowing frames are dropped whole.
module asic_result_packetizer #(
    parameter int DEPTH      = 256,
    parameter int DESC_DEPTH = 4,
    parameter int ERR_W      = 7
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cap_valid,
    input  logic        cap_last,
    input  logic        cap_testready,
    input  logic        cap_start,
    input  logic        cap_keepshift,
    input  logic        cap_bitout,
    input  logic [6:0]  cap_tout,
    output logic [31:0] src_data,
    output logic        src_valid,
    input  logic        src_ready,
    output logic        src_startofpacket,
    output logic        src_endofpacket,
    output logic        overflow,
    output logic [7:0]  dropped_frames
);
    localparam int AW  = $clog2(DEPTH);
    localparam int PW  = AW + 1;
    localparam int DAW = $clog2(DESC_DEPTH);
    localparam int DCW = DAW + 1;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    typedef enum logic [1:0] {IDLE, CAPTURE, DISCARD} cap_state_t;
    typedef enum logic {E_IDLE, E_SEND} emit_state_t;

    typedef struct packed {
        logic       last;
        logic       testready;
        logic       start;
        logic       keepshift;
        logic       bitout;
        logic [6:0] tout;
    } beat_t;

    beat_t            beat_mem [DEPTH];
    logic [ERR_W-1:0] desc_mem [DESC_DEPTH];

    cap_state_t       cap_state_q, cap_state_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    frm_base_q, frm_base_d;
    logic [PW-1:0]    commit_ptr_q, commit_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [ERR_W-1:0] err_acc_q, err_acc_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       dropped_q, dropped_d;

    logic [DAW-1:0]   desc_wr_q, desc_wr_d;
    logic [DAW-1:0]   desc_rd_q, desc_rd_d;
    logic [DCW-1:0]   desc_cnt_q, desc_cnt_d;

    emit_state_t      emit_state_q, emit_state_d;
    logic             src_valid_q, src_valid_d;
    logic             src_sop_q, src_sop_d;
    logic             src_eop_q, src_eop_d;
    logic [31:0]      src_data_q, src_data_d;

    beat_t            cap_beat;
    beat_t            rd_beat;
    logic             beat_we;
    logic             desc_push;
    logic             desc_pop;
    logic             drop;
    logic [ERR_W-1:0] desc_push_err;
    logic [ERR_W-1:0] err_next;
    logic [PW-1:0]    buf_used;
    logic             buf_full;
    logic             desc_full;
    logic [DAW-1:0]   desc_rd_nxt;
    logic [ERR_W-1:0] head_err;
    logic [ERR_W-1:0] next_err;

    function automatic logic [31:0] pack_beat(input beat_t b, input logic [ERR_W-1:0] err);
        logic [31:0] w;
        w             = '0;
        w[29]         = b.testready;
        w[27]         = b.start;
        w[26]         = b.keepshift;
        w[24]         = b.bitout;
        w[22:16]      = b.tout;
        w[ERR_W-1:0]  = err;
        return w;
    endfunction

    assign cap_beat    = {cap_last, cap_testready, cap_start, cap_keepshift, cap_bitout, cap_tout};
    assign rd_beat     = beat_mem[rd_ptr_q[AW-1:0]];
    assign buf_used    = wr_ptr_q - rd_ptr_q;
    assign buf_full    = (buf_used == PW'(DEPTH));
    assign desc_full   = (desc_cnt_q == DCW'(DESC_DEPTH));
    assign desc_rd_nxt = desc_rd_q + 1'b1;
    assign head_err    = desc_mem[desc_rd_q];
    assign next_err    = desc_mem[desc_rd_nxt];
    assign err_next    = (cap_keepshift && cap_bitout && err_acc_q != ERR_MAX) ?
                         err_acc_q + 1'b1 : err_acc_q;

    // Capture side: the frame is written speculatively and only published via commit_ptr.
    always_comb begin
        // NOTE: every signal gets a default first so no latch is inferred.
        cap_state_d   = cap_state_q;
        wr_ptr_d      = wr_ptr_q;
        frm_base_d    = frm_base_q;
        commit_ptr_d  = commit_ptr_q;
        err_acc_d     = err_acc_q;
        overflow_d    = overflow_q;
        dropped_d     = dropped_q;
        beat_we       = 1'b0;
        desc_push     = 1'b0;
        desc_push_err = '0;
        drop          = 1'b0;
        case (cap_state_q)
            IDLE: if (cap_valid) begin
                frm_base_d = wr_ptr_q;
                err_acc_d  = '0;
                if (buf_full) begin
                    if (cap_last) drop = 1'b1;
                    else          cap_state_d = DISCARD;
                end else begin
                    beat_we  = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (cap_last) begin
                        if (desc_full) begin
                            drop     = 1'b1;
                            wr_ptr_d = wr_ptr_q;
                        end else begin
                            desc_push    = 1'b1;
                            commit_ptr_d = wr_ptr_q + 1'b1;
                        end
                    end else begin
                        cap_state_d = CAPTURE;
                    end
                end
            end
            CAPTURE: if (cap_valid) begin
                if (buf_full) begin
                    if (cap_last) begin
                        drop        = 1'b1;
                        wr_ptr_d    = frm_base_q;
                        cap_state_d = IDLE;
                    end else begin
                        cap_state_d = DISCARD;
                    end
                end else begin
                    beat_we   = 1'b1;
                    wr_ptr_d  = wr_ptr_q + 1'b1;
                    err_acc_d = err_next;
                    if (cap_last) begin
                        cap_state_d = IDLE;
                        if (desc_full) begin
                            drop     = 1'b1;
                            wr_ptr_d = frm_base_q;
                        end else begin
                            desc_push     = 1'b1;
                            desc_push_err = err_next;
                            commit_ptr_d  = wr_ptr_q + 1'b1;
                        end
                    end
                end
            end
            DISCARD: if (cap_valid && cap_last) begin
                drop        = 1'b1;
                wr_ptr_d    = frm_base_q;
                cap_state_d = IDLE;
            end
            default: cap_state_d = IDLE;
        endcase
        if (drop) begin
            overflow_d = 1'b1;
            if (dropped_q != 8'hFF) dropped_d = dropped_q + 1'b1;
        end
    end

    // Emit side: output registers always hold the beat currently offered to the sink.
    always_comb begin
        emit_state_d = emit_state_q;
        rd_ptr_d     = rd_ptr_q;
        src_valid_d  = src_valid_q;
        src_sop_d    = src_sop_q;
        src_eop_d    = src_eop_q;
        src_data_d   = src_data_q;
        desc_pop     = 1'b0;
        case (emit_state_q)
            E_IDLE: if (desc_cnt_q != '0 && rd_ptr_q != commit_ptr_q) begin
                emit_state_d = E_SEND;
                src_valid_d  = 1'b1;
                src_sop_d    = 1'b1;
                src_eop_d    = rd_beat.last;
                src_data_d   = pack_beat(rd_beat, head_err);
                rd_ptr_d     = rd_ptr_q + 1'b1;
            end
            E_SEND: if (src_ready) begin
                if (src_eop_q) begin
                    desc_pop = 1'b1;
                    if (desc_cnt_q > DCW'(1)) begin
                        src_sop_d  = 1'b1;
                        src_eop_d  = rd_beat.last;
                        src_data_d = pack_beat(rd_beat, next_err);
                        rd_ptr_d   = rd_ptr_q + 1'b1;
                    end else begin
                        emit_state_d = E_IDLE;
                        src_valid_d  = 1'b0;
                        src_sop_d    = 1'b0;
                        src_eop_d    = 1'b0;
                    end
                end else begin
                    src_sop_d  = 1'b0;
                    src_eop_d  = rd_beat.last;
                    src_data_d = pack_beat(rd_beat, head_err);
                    rd_ptr_d   = rd_ptr_q + 1'b1;
                end
            end
            default: emit_state_d = E_IDLE;
        endcase
    end

    always_comb begin
        desc_wr_d  = desc_push ? desc_wr_q + 1'b1 : desc_wr_q;
        desc_rd_d  = desc_pop  ? desc_rd_nxt      : desc_rd_q;
        desc_cnt_d = desc_cnt_q;
        case ({desc_push, desc_pop})
            2'b10:   desc_cnt_d = desc_cnt_q + 1'b1;
            2'b01:   desc_cnt_d = desc_cnt_q - 1'b1;
            default: desc_cnt_d = desc_cnt_q;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_state_q  <= IDLE;
            wr_ptr_q     <= '0;
            frm_base_q   <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            err_acc_q    <= '0;
            overflow_q   <= 1'b0;
            dropped_q    <= '0;
            desc_wr_q    <= '0;
            desc_rd_q    <= '0;
            desc_cnt_q   <= '0;
            emit_state_q <= E_IDLE;
            src_valid_q  <= 1'b0;
            src_sop_q    <= 1'b0;
            src_eop_q    <= 1'b0;
            src_data_q   <= '0;
        end else begin
            cap_state_q  <= cap_state_d;
            wr_ptr_q     <= wr_ptr_d;
            frm_base_q   <= frm_base_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            err_acc_q    <= err_acc_d;
            overflow_q   <= overflow_d;
            dropped_q    <= dropped_d;
            desc_wr_q    <= desc_wr_d;
            desc_rd_q    <= desc_rd_d;
            desc_cnt_q   <= desc_cnt_d;
            emit_state_q <= emit_state_d;
            src_valid_q  <= src_valid_d;
            src_sop_q    <= src_sop_d;
            src_eop_q    <= src_eop_d;
            src_data_q   <= src_data_d;
        end
    end

    // NOTE: storage arrays are not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (beat_we)   beat_mem[wr_ptr_q[AW-1:0]] <= cap_beat;
        if (desc_push) desc_mem[desc_wr_q]         <= desc_push_err;
    end

    assign src_valid         = src_valid_q;
    assign src_startofpacket = src_sop_q;
    assign src_endofpacket   = src_eop_q;
    assign src_data          = src_data_q;
    assign overflow          = overflow_q;
    assign dropped_frames    = dropped_q;

endmodule

// File: doc/asic_result_packetizer.md
Name: asic_result_packetizer

Overview:
- Return-path (ASIC→FPGA) half of the asic_avalon interface.
- Captures per-cycle ASIC result samples (TestReady, Start, KeepShift, bitout, TOut) into a frame buffer and computes the frame's bit-error count in hardware.
- Emits each completed frame as one Avalon-ST packet on a 32-bit source port toward the host/sink.
- Frames that overflow the buffer are discarded whole (commit/rollback), so the sink only ever sees complete, consistent packets.

Parameters:
- DEPTH, 256, beat-buffer entries (power of 2); must be ≥ longest frame (202).
- DESC_DEPTH, 4, completed-frame descriptor FIFO entries (power of 2).
- ERR_W, 7, width of error count; saturates at 2^ERR_W-1.

Ports:
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- cap_valid  in  1  capture beat present this cycle; no backpressure to the ASIC side.
- cap_last  in  1  final beat of the frame; qualified by cap_valid.
- cap_testready  in  1  ASIC TestReady sample.
- cap_start  in  1  ASIC Start sample.
- cap_keepshift  in  1  ASIC KeepShift sample.
- cap_bitout  in  1  ASIC bitout sample.
- cap_tout  in  7  ASIC TOut sample.
- src_data  out  32  Avalon-ST data.
- src_valid  out  1  Avalon-ST valid.
- src_ready  in  1  Avalon-ST ready; readyLatency = 0.
- src_startofpacket  out  1  first beat of packet.
- src_endofpacket  out  1  last beat of packet.
- overflow  out  1  sticky; set when any frame is dropped.
- dropped_frames  out  8  count of discarded frames; saturates at 255.

Behaviour:
- Reset: async clear of all pointers, FSMs and counters. src_valid=0, src_startofpacket=0, src_endofpacket=0, src_data=0, overflow=0, dropped_frames=0. Reset mid-packet abandons the packet; there is no resume.
- Capture FSM states: IDLE, CAPTURE, DISCARD.
  - IDLE: a cap_valid beat opens a frame and saves wr_ptr to frm_base. That beat is beat 0, and its error contribution is excluded.
  - CAPTURE: each beat is written as 12 bits: testready, start, keepshift, bitout, tout, plus a last flag.
  - err_acc increments on every non-first beat with keepshift&bitout, saturating.
  - A beat arriving while the buffer is full (wr_ptr−rd_ptr==DEPTH) is not written; the FSM enters DISCARD.
  - A 1-beat frame (cap_valid&cap_last while IDLE) is legal; its err=0.
  - cap_valid&cap_last in CAPTURE with a free descriptor slot: write descriptor {err_acc}, commit wr_ptr to the reader (commit_ptr=wr_ptr+1), return to IDLE.
  - If the descriptor FIFO is full at cap_last: roll wr_ptr back to frm_base, set overflow, increment dropped_frames, return to IDLE.
  - DISCARD: ignore beats until cap_last, then roll back, set overflow and increment dropped_frames as above, then IDLE.
- The reader sees only committed beats. An uncommitted frame is never emitted.
- Emit FSM states: E_IDLE, E_SEND.
  - E_IDLE: when the descriptor FIFO is non-empty, move to E_SEND. The descriptor is written at edge N+1 after the cap_last beat in cycle N; src_valid is asserted in cycle N+2 at the earliest.
  - Beat mapping: [29]=testready, [27]=start, [26]=keepshift, [24]=bitout, [22:16]=tout, [ERR_W-1:0]=head-descriptor err (identical on every beat of the packet). All other bits are 0.
  - src_startofpacket=1 on the first beat. src_endofpacket = stored last flag.
  - While src_valid&!src_ready, src_data, src_startofpacket and src_endofpacket are held stable.
  - A beat advances on src_valid&src_ready. Full throughput: 1 beat/cycle while ready is held high.
  - On eop&ready: pop the descriptor. Go to E_IDLE, or start the next packet with no bubble required if another descriptor is present.
- Capture and emit operate concurrently. Simultaneous commit and pop in the same cycle update the descriptor count correctly (net 0).
- Pointers are log2(DEPTH)+1 bits and wrap naturally; full/empty are derived from the MSB difference.

Test Plan:
- Reset, then a 202-beat frame: beat 0 has keepshift=bitout=1, and 5 other beats have keepshift=bitout=1; src_ready=1 → 202-beat packet, sop on beat 0, eop on beat 201, data[6:0]=5 on every beat, [22:16] equals the captured tout sequence.
- Same frame with 150 error beats → data[6:0]=127 (saturated).
- Random src_ready (~50% low) over 3 back-to-back frames → no beat lost or duplicated, data stable during stalls, packets in order, no sop/eop bubble errors.
- Frame of DEPTH+10 beats with src_ready=0 → frame dropped, overflow=1, dropped_frames=1. The next 10-beat frame is emitted intact.
- Hold src_ready=0 and capture 5 short frames with DESC_DEPTH=4 → 5th frame dropped, dropped_frames=1. After ready rises, exactly 4 packets are emitted.
- Assert reset_n low mid-packet (beat 50) → src_valid drops asynchronously. After release, a new frame is emitted from sop with err recomputed.
